// File: rtl/period_detector_if.sv
// ---------------------------------------------------------------------------
// period_detector_if
//   Sample-in / period-out bundle for period_detector.
//   master : sample source and period consumer (drives sample_in/sample_valid)
//   slave  : the detector (drives period_out/period_valid/locked)
// Signals
//   sample_in     signed sample, 20 fraction bits (+/-1.0 = +/-2^20)
//   sample_valid  sample_in is valid this cycle
//   period_out    last accepted period, in valid samples
//   period_valid  one-cycle pulse: period_out was updated
//   locked        at least one period accepted since last reset/timeout
// ---------------------------------------------------------------------------
interface period_detector_if;
    logic signed [31:0] sample_in;
    logic               sample_valid;
    logic        [31:0] period_out;
    logic               period_valid;
    logic               locked;

    modport master (
        output sample_in,
        output sample_valid,
        input  period_out,
        input  period_valid,
        input  locked
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output period_out,
        output period_valid,
        output locked
    );
endinterface

// File: rtl/period_detector.sv
// ---------------------------------------------------------------------------
// period_detector
//   Measures the period (samples per cycle) of a periodic signed sample
//   stream by timing rising zero crossings detected with hysteresis.
//   Optional build macro PERIOD_AVG_EN: report the truncated mean of the
//   last four accepted periods (one extra cycle of latency).
// Ports
//   clk      in  clock
//   reset_n  in  synchronous reset, active low
//   bus      slave modport of period_detector_if
//            (sample_in, sample_valid in; period_out, period_valid, locked out)
// ---------------------------------------------------------------------------
module period_detector #(
    parameter logic signed [31:0] HYST       = 32'sh0001_0000,
    parameter logic        [31:0] MIN_PERIOD = 32'd2,
    parameter logic        [31:0] MAX_PERIOD = 32'h0100_0000
) (
    input  logic             clk,
    input  logic             reset_n,
    period_detector_if.slave bus
);

    localparam logic signed [31:0] NEG_HYST = -HYST;

    typedef enum logic {
        SEEK_LOW  = 1'b0,
        SEEK_HIGH = 1'b1
    } state_t;

    state_t      state_q;
    logic        have_ref_q;
    logic [31:0] cnt_q;

    // Measurement stage outputs (one cycle after the crossing sample).
    logic        vld_p0_q;
    logic        tout_p0_q;
    logic [31:0] per_p0_q;

    // Output registers.
    logic [31:0] period_q;
    logic        period_valid_q;
    logic        locked_q;

    logic        below;
    logic        above;
    logic        crossing;
    logic [31:0] cnt_inc;

    assign below    = bus.sample_in <  NEG_HYST;
    assign above    = bus.sample_in >= HYST;
    assign crossing = (state_q == SEEK_HIGH) && above;
    // The crossing sample itself belongs to the period being closed.
    assign cnt_inc  = cnt_q + 32'd1;

    // ---- stage p0: crossing FSM and sample counter ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= SEEK_LOW;
            have_ref_q <= 1'b0;
            cnt_q      <= '0;
            vld_p0_q   <= 1'b0;
            tout_p0_q  <= 1'b0;
            per_p0_q   <= '0;
        end else begin
            vld_p0_q  <= 1'b0;
            tout_p0_q <= 1'b0;
            if (bus.sample_valid) begin
                if (crossing) begin
                    // A crossing beats a timeout on the same sample, so a
                    // period of exactly MAX_PERIOD is still accepted.
                    state_q <= SEEK_LOW;
                    if (!have_ref_q) begin
                        have_ref_q <= 1'b1;
                        cnt_q      <= '0;
                    end else if (cnt_inc < MIN_PERIOD) begin
                        // Too short to be real: treat as a glitch and keep
                        // timing from the original reference.
                        cnt_q <= cnt_inc;
                    end else begin
                        per_p0_q <= cnt_inc;
                        vld_p0_q <= 1'b1;
                        cnt_q    <= '0;
                    end
                end else if (have_ref_q && (cnt_inc == MAX_PERIOD)) begin
                    tout_p0_q  <= 1'b1;
                    have_ref_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= SEEK_LOW;
                end else begin
                    if ((state_q == SEEK_LOW) && below) begin
                        state_q <= SEEK_HIGH;
                    end
                    if (have_ref_q) begin
                        cnt_q <= cnt_inc;
                    end
                end
            end
        end
    end

    logic        out_vld;
    logic        out_tout;
    logic [31:0] out_val;

`ifdef PERIOD_AVG_EN
    logic [31:0] hist_q [4];
    logic        hist_ld_q;
    logic        vld_p1_q;
    logic        tout_p1_q;
    logic [33:0] sum_d;

    // ---- stage p1: period history ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            hist_ld_q <= 1'b0;
            vld_p1_q  <= 1'b0;
            tout_p1_q <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p0_q;
            tout_p1_q <= tout_p0_q;
            if (vld_p0_q) begin
                if (!hist_ld_q) begin
                    // First period after acquiring lock seeds every tap so
                    // the mean is meaningful immediately.
                    for (int i = 0; i < 4; i++) begin
                        hist_q[i] <= per_p0_q;
                    end
                    hist_ld_q <= 1'b1;
                end else begin
                    hist_q[0] <= per_p0_q;
                    for (int i = 1; i < 4; i++) begin
                        hist_q[i] <= hist_q[i-1];
                    end
                end
            end else if (tout_p0_q) begin
                for (int i = 0; i < 4; i++) begin
                    hist_q[i] <= '0;
                end
                hist_ld_q <= 1'b0;
            end
        end
    end

    always_comb begin
        sum_d = {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
              + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
    end

    assign out_vld  = vld_p1_q;
    assign out_tout = tout_p1_q;
    assign out_val  = sum_d[33:2];
`else
    assign out_vld  = vld_p0_q;
    assign out_tout = tout_p0_q;
    assign out_val  = per_p0_q;
`endif

    // ---- output stage: period, pulse and lock flag ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            period_valid_q <= out_vld;
            if (out_vld) begin
                period_q <= out_val;
                locked_q <= 1'b1;
            end else if (out_tout) begin
                // period_out deliberately keeps the last accepted value.
                locked_q <= 1'b0;
            end
        end
    end

    assign bus.period_out   = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = locked_q;

endmodule

// File: tb/tb_period_detector.sv
module tb_period_detector;

`ifdef PERIOD_AVG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic signed [31:0] HI = 32'sd524288;
    localparam logic signed [31:0] LO = -32'sd524288;

    logic clk;
    logic reset_n;
    period_detector_if bus ();

    period_detector #(
        .HYST       (32'sh0001_0000),
        .MIN_PERIOD (32'd80),
        .MAX_PERIOD (32'd1000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log: cycle number and value of every period_valid pulse.
    int          pc[$];
    logic [31:0] pv[$];
    logic        prev_pv = 1'b0;
    int          dbl = 0;

    always @(negedge clk) begin
        if (bus.period_valid === 1'b1) begin
            pc.push_back(cyc);
            pv.push_back(bus.period_out);
            if (prev_pv) dbl++;
        end
        prev_pv = (bus.period_valid === 1'b1);
    end

    task automatic step(input logic signed [31:0] s, input logic v);
        bus.sample_in    = s;
        bus.sample_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [31:0] saw(input int i);
        int v;
        v = -1048576 + (i % 100) * 20971;
        return v;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        step(32'sd0, 1'b0);
        reset_n = 1'b1;
        pc.delete();
        pv.delete();
    endtask

    task automatic low_run(input int n);
        for (int k = 0; k < n; k++) step(LO, 1'b1);
    endtask

    // One square cycle: first half high, rest low; optional spike offset.
    task automatic sq_cycle(input int len, input int spike);
        for (int o = 0; o < len; o++) begin
            if (o < len / 2 || o == spike) step(HI, 1'b1);
            else step(LO, 1'b1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(32'sd0, 1'b0);
        step(32'sd0, 1'b0);
        reset_n = 1'b1;
        pc.delete();
        pv.delete();
        checks++;
        if (bus.period_out !== 32'd0) begin
            errors++; $display("FAIL reset_period_out: got %0d want 0", bus.period_out);
        end
        checks++;
        if (bus.period_valid !== 1'b0) begin
            errors++; $display("FAIL reset_period_valid: got %b want 0", bus.period_valid);
        end
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++; $display("FAIL reset_locked: got %b want 0", bus.locked);
        end
    endtask

    task automatic test_sawtooth();
        int start;
        do_reset();
        start = cyc;
        for (int i = 0; i < 400; i++) step(saw(i), 1'b1);
        checks++;
        if (pc.size() !== 3) begin
            errors++; $display("FAIL saw_pulse_count: got %0d want 3", pc.size());
        end
        for (int j = 0; j < pc.size(); j++) begin
            checks++;
            if (pv[j] !== 32'd100) begin
                errors++; $display("FAIL saw_period[%0d]: got %0d want 100", j, pv[j]);
            end
            checks++;
            if (pc[j] - start !== 154 + 100 * j + 1 + LAT) begin
                errors++; $display("FAIL saw_timing[%0d]: got %0d want %0d", j, pc[j] - start, 154 + 100 * j + 1 + LAT);
            end
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++; $display("FAIL saw_locked: got %b want 1", bus.locked);
        end
    endtask

    task automatic test_sparse_valid();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(saw(i), 1'b1);
            step(32'sh7FFF_FFFF, 1'b0);
            step(32'sh8000_0001, 1'b0);
        end
        checks++;
        if (pc.size() !== 3) begin
            errors++; $display("FAIL sparse_pulse_count: got %0d want 3", pc.size());
        end
        for (int j = 0; j < pc.size(); j++) begin
            checks++;
            if (pv[j] !== 32'd100) begin
                errors++; $display("FAIL sparse_period[%0d]: got %0d want 100", j, pv[j]);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        low_run(10);
        sq_cycle(100, -1);
        sq_cycle(100, 75);
        sq_cycle(100, -1);
        checks++;
        if (pc.size() !== 2) begin
            errors++; $display("FAIL glitch_pulse_count: got %0d want 2", pc.size());
        end
        for (int j = 0; j < pc.size(); j++) begin
            checks++;
            if (pv[j] !== 32'd100) begin
                errors++; $display("FAIL glitch_period[%0d]: got %0d want 100", j, pv[j]);
            end
        end
    endtask

    task automatic test_timeout();
        int start;
        do_reset();
        for (int i = 0; i < 255; i++) step(saw(i), 1'b1);
        for (int k = 1; k <= 999 + LAT; k++) step(32'sd0, 1'b1);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++; $display("FAIL timeout_locked_before: got %b want 1", bus.locked);
        end
        step(32'sd0, 1'b1);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++; $display("FAIL timeout_locked_after: got %b want 0", bus.locked);
        end
        checks++;
        if (bus.period_out !== 32'd100) begin
            errors++; $display("FAIL timeout_period_hold: got %0d want 100", bus.period_out);
        end
        checks++;
        if (pc.size() !== 2) begin
            errors++; $display("FAIL timeout_pulse_count: got %0d want 2", pc.size());
        end
        // Relock after timeout needs a fresh reference crossing.
        pc.delete();
        pv.delete();
        start = cyc;
        for (int i = 0; i < 200; i++) step(saw(i), 1'b1);
        checks++;
        if (pc.size() !== 1) begin
            errors++; $display("FAIL relock_pulse_count: got %0d want 1", pc.size());
        end
        if (pc.size() > 0) begin
            checks++;
            if (pc[0] - start !== 155 + LAT) begin
                errors++; $display("FAIL relock_timing: got %0d want %0d", pc[0] - start, 155 + LAT);
            end
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++; $display("FAIL relock_locked: got %b want 1", bus.locked);
        end
    endtask

    task automatic test_reset_mid();
        int start;
        do_reset();
        for (int i = 0; i < 260; i++) step(saw(i), 1'b1);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++; $display("FAIL mid_locked_pre: got %b want 1", bus.locked);
        end
        reset_n = 1'b0;
        step(saw(260), 1'b1);
        reset_n = 1'b1;
        checks++;
        if (bus.period_out !== 32'd0) begin
            errors++; $display("FAIL mid_period_out: got %0d want 0", bus.period_out);
        end
        checks++;
        if (bus.period_valid !== 1'b0) begin
            errors++; $display("FAIL mid_period_valid: got %b want 0", bus.period_valid);
        end
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++; $display("FAIL mid_locked: got %b want 0", bus.locked);
        end
        pc.delete();
        pv.delete();
        start = cyc;
        for (int i = 0; i < 200; i++) step(saw(i), 1'b1);
        checks++;
        if (pc.size() !== 1) begin
            errors++; $display("FAIL mid_relock_count: got %0d want 1", pc.size());
        end
        if (pc.size() > 0) begin
            checks++;
            if (pc[0] - start !== 155 + LAT) begin
                errors++; $display("FAIL mid_relock_timing: got %0d want %0d", pc[0] - start, 155 + LAT);
            end
        end
    endtask

    task automatic test_max_period();
        do_reset();
        low_run(10);
        for (int c = 0; c < 3; c++) sq_cycle(1000, -1);
        checks++;
        if (pc.size() !== 2) begin
            errors++; $display("FAIL max_pulse_count: got %0d want 2", pc.size());
        end
        for (int j = 0; j < pc.size(); j++) begin
            checks++;
            if (pv[j] !== 32'd1000) begin
                errors++; $display("FAIL max_period[%0d]: got %0d want 1000", j, pv[j]);
            end
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++; $display("FAIL max_locked: got %b want 1", bus.locked);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        logic [31:0] exp_v [4];
        int lens [5];
        lens = '{100, 100, 100, 104, 100};
`ifdef PERIOD_AVG_EN
        exp_v = '{32'd100, 32'd100, 32'd100, 32'd101};
`else
        exp_v = '{32'd100, 32'd100, 32'd100, 32'd104};
`endif
        do_reset();
        start = cyc;
        low_run(10);
        for (int c = 0; c < 5; c++) sq_cycle(lens[c], -1);
        checks++;
        if (pc.size() !== 4) begin
            errors++; $display("FAIL b2b_pulse_count: got %0d want 4", pc.size());
        end
        for (int j = 0; j < pc.size() && j < 4; j++) begin
            checks++;
            if (pv[j] !== exp_v[j]) begin
                errors++; $display("FAIL b2b_period[%0d]: got %0d want %0d", j, pv[j], exp_v[j]);
            end
        end
        if (pc.size() >= 4) begin
            checks++;
            if (pc[3] - start !== 415 + LAT) begin
                errors++; $display("FAIL b2b_timing: got %0d want %0d", pc[3] - start, 415 + LAT);
            end
        end
        checks++;
        if (dbl !== 0) begin
            errors++; $display("FAIL pulse_spacing: got %0d adjacent pulses want 0", dbl);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.sample_in    = 32'sd0;
        bus.sample_valid = 1'b0;
        test_reset();
        test_sawtooth();
        test_sparse_valid();
        test_glitch();
        test_timeout();
        test_reset_mid();
        test_max_period();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
